sad_min_scheduler: RTL and testbench

- Sequential minimum-SAD search controller for the VBSME motion-estimation datapath.
- Accepts one candidate SAD per cycle from the SAD array / pairwise-compare tree, in raster order over a SEARCH_W x SEARCH_H search window.
- Keeps a running minimum, counts window positions itself, and reports the winning SAD, linear index, row and column once per search.
- Sits between the compare-reduction stage and the top-level motion-vector output register.

---
 rtl/sad_min_scheduler.sv | 159 +++++++++++++++
 tb/tb_sad_min_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_min_scheduler.sv
// Sequential minimum-SAD search controller: takes one candidate SAD per accept in
// raster order, tracks the running minimum and reports its SAD, index, row and column.
module sad_min_scheduler #(
   parameter int SEARCH_W = 61,
   parameter int SEARCH_H = 61,
   parameter int SAD_W    = 32,
   parameter int IDX_W    = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             start,
   input  logic             abort,
   input  logic             cand_valid,
   input  logic [SAD_W-1:0] cand_sad,
   output logic             cand_ready,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ack,
   output logic [SAD_W-1:0] best_sad,
   output logic [IDX_W-1:0] best_index,
   output logic [IDX_W-1:0] best_row,
   output logic [IDX_W-1:0] best_col
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(SEARCH_W - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEARCH_W * SEARCH_H - 1);

   state_t           r_state;
   logic             r_cand_ready;
   logic             r_busy;
   logic             r_result_valid;

   logic [IDX_W-1:0] r_row;
   logic [IDX_W-1:0] r_col;
   logic [IDX_W-1:0] r_count;

   logic [SAD_W-1:0] r_min_sad;
   logic [IDX_W-1:0] r_min_idx;
   logic [IDX_W-1:0] r_min_row;
   logic [IDX_W-1:0] r_min_col;

   logic [SAD_W-1:0] r_best_sad;
   logic [IDX_W-1:0] r_best_idx;
   logic [IDX_W-1:0] r_best_row;
   logic [IDX_W-1:0] r_best_col;

   logic             w_accept;
   logic             w_take;
   logic             w_last;
   logic [SAD_W-1:0] w_nxt_sad;
   logic [IDX_W-1:0] w_nxt_idx;
   logic [IDX_W-1:0] w_nxt_row;
   logic [IDX_W-1:0] w_nxt_col;

   // NOTE: the post-accept minimum is formed combinationally so that the final
   // accept can load best_* on the same edge that enters DONE (one-cycle latency).
   // The <= compare lets a later equal candidate win, like the pairwise compare tree.
   assign w_accept  = r_cand_ready & cand_valid;
   assign w_take    = (cand_sad <= r_min_sad);
   assign w_last    = (r_count == LAST_IDX);
   assign w_nxt_sad = w_take ? cand_sad : r_min_sad;
   assign w_nxt_idx = w_take ? r_count  : r_min_idx;
   assign w_nxt_row = w_take ? r_row    : r_min_row;
   assign w_nxt_col = w_take ? r_col    : r_min_col;

   // NOTE: all state is sequential and uses non-blocking assignments only.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state        <= S_IDLE;
         r_cand_ready   <= 1'b0;
         r_busy         <= 1'b0;
         r_result_valid <= 1'b0;
         r_row          <= '0;
         r_col          <= '0;
         r_count        <= '0;
         r_min_sad      <= '1;
         r_min_idx      <= '0;
         r_min_row      <= '0;
         r_min_col      <= '0;
         r_best_sad     <= '1;
         r_best_idx     <= '0;
         r_best_row     <= '0;
         r_best_col     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state      <= S_ACCUM;
                  r_cand_ready <= 1'b1;
                  r_busy       <= 1'b1;
                  r_row        <= '0;
                  r_col        <= '0;
                  r_count      <= '0;
                  r_min_sad    <= '1;
                  r_min_idx    <= '0;
                  r_min_row    <= '0;
                  r_min_col    <= '0;
               end
            end

            S_ACCUM: begin
               if (abort) begin
                  r_state      <= S_IDLE;
                  r_cand_ready <= 1'b0;
                  r_busy       <= 1'b0;
               end else if (w_accept) begin
                  r_min_sad <= w_nxt_sad;
                  r_min_idx <= w_nxt_idx;
                  r_min_row <= w_nxt_row;
                  r_min_col <= w_nxt_col;
                  r_count   <= r_count + IDX_ONE;
                  if (r_col == LAST_COL) begin
                     r_col <= '0;
                     r_row <= r_row + IDX_ONE;
                  end else begin
                     r_col <= r_col + IDX_ONE;
                  end
                  if (w_last) begin
                     r_state        <= S_DONE;
                     r_cand_ready   <= 1'b0;
                     r_result_valid <= 1'b1;
                     r_best_sad     <= w_nxt_sad;
                     r_best_idx     <= w_nxt_idx;
                     r_best_row     <= w_nxt_row;
                     r_best_col     <= w_nxt_col;
                  end
               end
            end

            S_DONE: begin
               if (result_ack) begin
                  r_state        <= S_IDLE;
                  r_result_valid <= 1'b0;
                  r_busy         <= 1'b0;
               end
            end

            default: begin
               r_state        <= S_IDLE;
               r_cand_ready   <= 1'b0;
               r_busy         <= 1'b0;
               r_result_valid <= 1'b0;
            end
         endcase
      end
   end

   assign cand_ready   = r_cand_ready;
   assign busy         = r_busy;
   assign result_valid = r_result_valid;
   assign best_sad     = r_best_sad;
   assign best_index   = r_best_idx;
   assign best_row     = r_best_row;
   assign best_col     = r_best_col;

endmodule

// File: tb/tb_sad_min_scheduler.sv
// Directed bench for sad_min_scheduler on a 4x3 search window.
module tb_sad_min_scheduler;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        start, abort, cand_valid, result_ack;
   logic [31:0] cand_sad;
   logic        cand_ready, busy, result_valid;
   logic [31:0] best_sad, best_index, best_row, best_col;

   int checks = 0;
   int errors = 0;

   logic [31:0] s_main [N] = '{50, 40, 30, 20, 10, 60, 70, 80, 90, 15, 25, 35};
   logic [31:0] s_tie  [N] = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
   logic [31:0] s_desc [N] = '{12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
   logic [31:0] s_ones [N] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

   sad_min_scheduler #(.SEARCH_W(W), .SEARCH_H(H), .SAD_W(32), .IDX_W(32)) dut (
      .Clk(Clk), .Rst(Rst), .start(start), .abort(abort),
      .cand_valid(cand_valid), .cand_sad(cand_sad), .cand_ready(cand_ready),
      .busy(busy), .result_valid(result_valid), .result_ack(result_ack),
      .best_sad(best_sad), .best_index(best_index), .best_row(best_row), .best_col(best_col)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   // Starts a search and feeds the first n candidates; counts any early result_valid
   // and any cycle in ACCUM where cand_ready was low.
   task automatic drive_search(input logic [31:0] s [N], input bit gapped, input int n,
                               output int early_rv, output int ready_low);
      early_rv  = 0;
      ready_low = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (gapped) begin
            cand_valid = 1'b0;
            cand_sad   = 32'd0;
            if (!cand_ready) ready_low++;
            if (result_valid) early_rv++;
            step();
         end
         cand_valid = 1'b1;
         cand_sad   = s[i];
         if (!cand_ready) ready_low++;
         if (result_valid) early_rv++;
         step();
      end
      cand_valid = 1'b0;
      cand_sad   = 32'd0;
   endtask

   task automatic ack_result();
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
   endtask

   task automatic test_reset();
      Rst = 1'b1; start = 1'b0; abort = 1'b0; cand_valid = 1'b0; result_ack = 1'b0; cand_sad = '0;
      repeat (2) @(posedge Clk);
      #1;
      checks++;
      if ({cand_ready, busy, result_valid, best_sad, best_index, best_row, best_col} !==
          {3'b000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL reset_state: got rdy=%0b busy=%0b rv=%0b sad=%h idx=%0d row=%0d col=%0d, want 0 0 0 ffffffff 0 0 0",
                  cand_ready, busy, result_valid, best_sad, best_index, best_row, best_col);
      end
      Rst = 1'b0;
      step();
      cand_valid = 1'b1;
      repeat (3) step();
      cand_valid = 1'b0;
      checks++;
      if ({cand_ready, busy, result_valid} !== 3'b000) begin
         errors++;
         $display("FAIL idle_ignores_valid: got rdy=%0b busy=%0b rv=%0b, want 0 0 0", cand_ready, busy, result_valid);
      end
   endtask

   task automatic test_basic();
      int early, low;
      drive_search(s_main, 1'b0, N, early, low);
      checks++;
      if (early !== 0 || low !== 0) begin
         errors++;
         $display("FAIL basic_stream: got early_rv=%0d ready_low=%0d, want 0 0", early, low);
      end
      checks++;
      if ({result_valid, busy, cand_ready, best_sad, best_index, best_row, best_col} !==
          {3'b110, 32'd10, 32'd4, 32'd1, 32'd0}) begin
         errors++;
         $display("FAIL basic_result: got rv=%0b busy=%0b rdy=%0b sad=%0d idx=%0d row=%0d col=%0d, want 1 1 0 10 4 1 0",
                  result_valid, busy, cand_ready, best_sad, best_index, best_row, best_col);
      end
      ack_result();
      checks++;
      if ({result_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL basic_ack: got rv=%0b busy=%0b, want 0 0", result_valid, busy);
      end
   endtask

   task automatic test_tie();
      int early, low;
      drive_search(s_tie, 1'b0, N, early, low);
      checks++;
      if ({result_valid, best_sad, best_index, best_row, best_col} !== {1'b1, 32'd7, 32'd11, 32'd2, 32'd3}) begin
         errors++;
         $display("FAIL tie_result: got rv=%0b sad=%0d idx=%0d row=%0d col=%0d, want 1 7 11 2 3",
                  result_valid, best_sad, best_index, best_row, best_col);
      end
      ack_result();
   endtask

   task automatic test_gapped();
      int early, low;
      drive_search(s_main, 1'b1, N, early, low);
      checks++;
      if (early !== 0 || low !== 0) begin
         errors++;
         $display("FAIL gapped_stream: got early_rv=%0d ready_low=%0d, want 0 0", early, low);
      end
      checks++;
      if ({result_valid, best_sad, best_index, best_row, best_col} !== {1'b1, 32'd10, 32'd4, 32'd1, 32'd0}) begin
         errors++;
         $display("FAIL gapped_result: got rv=%0b sad=%0d idx=%0d row=%0d col=%0d, want 1 10 4 1 0",
                  result_valid, best_sad, best_index, best_row, best_col);
      end
      ack_result();
   endtask

   task automatic test_abort();
      int early, low, rv_seen;
      drive_search(s_ones, 1'b0, 5, early, low);
      abort = 1'b1;
      step();
      abort = 1'b0;
      rv_seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (result_valid) rv_seen++;
         step();
      end
      checks++;
      if ({busy, cand_ready, best_sad, best_index} !== {2'b00, 32'd10, 32'd4} || rv_seen !== 0) begin
         errors++;
         $display("FAIL abort_discard: got busy=%0b rdy=%0b sad=%0d idx=%0d rv_cycles=%0d, want 0 0 10 4 0",
                  busy, cand_ready, best_sad, best_index, rv_seen);
      end
      drive_search(s_desc, 1'b0, N, early, low);
      checks++;
      if ({result_valid, best_sad, best_index, best_row, best_col} !== {1'b1, 32'd1, 32'd11, 32'd2, 32'd3}) begin
         errors++;
         $display("FAIL abort_next_search: got rv=%0b sad=%0d idx=%0d row=%0d col=%0d, want 1 1 11 2 3",
                  result_valid, best_sad, best_index, best_row, best_col);
      end
      ack_result();
   endtask

   task automatic test_abort_last();
      int early, low;
      drive_search(s_main, 1'b0, N - 1, early, low);
      cand_valid = 1'b1;
      cand_sad   = 32'd0;
      abort      = 1'b1;
      step();
      cand_valid = 1'b0;
      abort      = 1'b0;
      step();
      checks++;
      if ({result_valid, busy, best_sad, best_index} !== {2'b00, 32'd1, 32'd11}) begin
         errors++;
         $display("FAIL abort_wins_last: got rv=%0b busy=%0b sad=%0d idx=%0d, want 0 0 1 11",
                  result_valid, busy, best_sad, best_index);
      end
   endtask

   task automatic test_hold_result();
      int early, low;
      drive_search(s_main, 1'b0, N, early, low);
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         step();
         start = 1'b0;
         checks++;
         if ({result_valid, busy, cand_ready, best_sad, best_index} !== {3'b110, 32'd10, 32'd4}) begin
            errors++;
            $display("FAIL hold_cycle_%0d: got rv=%0b busy=%0b rdy=%0b sad=%0d idx=%0d, want 1 1 0 10 4",
                     i, result_valid, busy, cand_ready, best_sad, best_index);
         end
      end
      result_ack = 1'b1;
      start      = 1'b1;
      step();
      result_ack = 1'b0;
      start      = 1'b0;
      step();
      checks++;
      if ({result_valid, busy, cand_ready} !== 3'b000) begin
         errors++;
         $display("FAIL ack_with_start: got rv=%0b busy=%0b rdy=%0b, want 0 0 0", result_valid, busy, cand_ready);
      end
      drive_search(s_tie, 1'b0, N, early, low);
      checks++;
      if ({result_valid, best_sad, best_index, best_row, best_col} !== {1'b1, 32'd7, 32'd11, 32'd2, 32'd3}) begin
         errors++;
         $display("FAIL hold_next_search: got rv=%0b sad=%0d idx=%0d row=%0d col=%0d, want 1 7 11 2 3",
                  result_valid, best_sad, best_index, best_row, best_col);
      end
      ack_result();
   endtask

   task automatic test_reset_mid_accum();
      int early, low;
      drive_search(s_main, 1'b0, 6, early, low);
      Rst = 1'b1;
      #1;
      checks++;
      if ({busy, cand_ready, result_valid, best_sad, best_index} !== {3'b000, 32'hFFFF_FFFF, 32'd0}) begin
         errors++;
         $display("FAIL reset_mid_accum: got busy=%0b rdy=%0b rv=%0b sad=%h idx=%0d, want 0 0 0 ffffffff 0",
                  busy, cand_ready, result_valid, best_sad, best_index);
      end
      step();
      Rst = 1'b0;
      step();
      drive_search(s_main, 1'b0, N, early, low);
      checks++;
      if ({result_valid, best_sad, best_index, best_row, best_col} !== {1'b1, 32'd10, 32'd4, 32'd1, 32'd0}) begin
         errors++;
         $display("FAIL after_reset_search: got rv=%0b sad=%0d idx=%0d row=%0d col=%0d, want 1 10 4 1 0",
                  result_valid, best_sad, best_index, best_row, best_col);
      end
      ack_result();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_gapped();
      test_abort();
      test_abort_last();
      test_hold_result();
      test_reset_mid_accum();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
